// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Producer-side hazard controller for a 5-stage MIPS pipeline. A shadow
// pipeline mirrors the destination register and remaining result latency
// (Tnew) of every in-flight writer in E, M and W. Each D-stage source is
// checked against these writers using its usage deadline (Tuse). A stall is
// raised when forwarding cannot deliver the value in time. The unit also
// owns the HI/LO (mult/div) busy counter.
//
// Parameters
//   MULT_CYCLES  latency of mult/multu
//   DIV_CYCLES   latency of div/divu (must fit the 4-bit counter, <= 15)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   rs_D, rt_D            D-stage source register numbers
//   tuse_rs_D, tuse_rt_D  cycles until the source is consumed (3 = unused)
//   dst_D, tnew_D         D-stage destination (0 = none) and result latency
//   md_start_D, md_div_D  D-stage mult/div start, 1 = divide
//   md_use_D              D-stage mfhi/mflo/mthi/mtlo
//   stall                 freeze PC and F/D, bubble into D/E
//   ready_M, ready_W      forwarding valid qualifiers for M and W
//   dst_M, dst_W          destinations of the M and W shadow entries
//   md_busy               HI/LO counter nonzero
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] dst_D,
    input  logic [1:0] tnew_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic       ready_M,
    output logic       ready_W,
    output logic [4:0] dst_M,
    output logic [4:0] dst_W,
    output logic       md_busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    // Shadow entries: p0 = E stage, p1 = M stage, p2 = W stage.
    logic [4:0] dst_e_p0;
    logic [1:0] tnew_e_p0;
    logic [4:0] dst_m_p1;
    logic [1:0] tnew_m_p1;
    logic [4:0] dst_w_p2;
    logic [3:0] md_cnt;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;

    // Remaining latency shrinks by one per stage and bottoms out at zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // The younger E writer masks an older M writer of the same register;
    // a W writer can always be forwarded, so it never stalls.
    function automatic logic src_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] d_e,
        input logic [1:0] t_e,
        input logic [4:0] d_m,
        input logic [1:0] t_m
    );
        if (src == 5'd0 || tuse == 2'd3) return 1'b0;
        if (d_e == src) return t_e > tuse;
        if (d_m == src) return t_m > tuse;
        return 1'b0;
    endfunction

    always_comb begin
        rs_stall = src_stall(rs_D, tuse_rs_D, dst_e_p0, tnew_e_p0, dst_m_p1, tnew_m_p1);
        rt_stall = src_stall(rt_D, tuse_rt_D, dst_e_p0, tnew_e_p0, dst_m_p1, tnew_m_p1);
        md_stall = (md_start_D | md_use_D) & (md_cnt != 4'd0);
        stall    = rs_stall | rt_stall | md_stall;
        ready_M  = (dst_m_p1 != 5'd0) & (tnew_m_p1 == 2'd0);
        ready_W  = (dst_w_p2 != 5'd0);
        dst_M    = dst_m_p1;
        dst_W    = dst_w_p2;
        md_busy  = (md_cnt != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_e_p0  <= 5'd0;
            tnew_e_p0 <= 2'd0;
            dst_m_p1  <= 5'd0;
            tnew_m_p1 <= 2'd0;
            dst_w_p2  <= 5'd0;
            md_cnt    <= 4'd0;
        end else begin
            // D -> E: a stall inserts a bubble that writes nothing.
            if (stall) begin
                dst_e_p0  <= 5'd0;
                tnew_e_p0 <= 2'd0;
            end else begin
                dst_e_p0  <= dst_D;
                tnew_e_p0 <= tnew_D;
            end
            // E -> M
            dst_m_p1  <= dst_e_p0;
            tnew_m_p1 <= sat_dec(tnew_e_p0);
            // M -> W
            dst_w_p2  <= dst_m_p1;
            // A stalled mult/div must not load; it loads when it advances.
            if (md_start_D && !stall)
                md_cnt <= md_div_D ? DIV_LOAD : MULT_LOAD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
    logic       md_start_D, md_div_D, md_use_D;
    logic       stall, ready_M, ready_W, md_busy;
    logic [4:0] dst_M, dst_W;

    hazard_stall_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .dst_D(dst_D), .tnew_D(tnew_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .stall(stall), .ready_M(ready_M), .ready_W(ready_W),
        .dst_M(dst_M), .dst_W(dst_W), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the last three instructions that entered E, kept with
    // their issue-time Tnew; age 0 is in E, 1 in M, 2 in W. The HI/LO unit
    // is modelled as an absolute cycle number at which it becomes free.
    int          cyc      = 0;
    int          md_until = 0;
    logic [4:0]  h_dst [3];
    int          h_tnew[3];

    function automatic int remaining(input int age);
        return (h_tnew[age] > age) ? h_tnew[age] - age : 0;
    endfunction

    function automatic bit model_src_stall(input logic [4:0] r, input logic [1:0] tu);
        if (r == 0 || tu == 3) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (h_dst[a] == r) return remaining(a) > int'(tu);
        return 1'b0;
    endfunction

    // Drive one D-stage instruction for one cycle, compare all outputs with
    // the model mid-cycle, then advance both DUT and model on the edge.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [1:0] tu_rs,
                        input logic [4:0] rt, input logic [1:0] tu_rt,
                        input logic [4:0] dst, input logic [1:0] tnew,
                        input logic ms, input logic mdiv, input logic mu,
                        output logic st);
        bit exp_stall, busy;
        reset = rst; rs_D = rs; tuse_rs_D = tu_rs; rt_D = rt; tuse_rt_D = tu_rt;
        dst_D = dst; tnew_D = tnew; md_start_D = ms; md_div_D = mdiv; md_use_D = mu;
        #1;
        busy      = md_until > cyc;
        exp_stall = model_src_stall(rs, tu_rs) | model_src_stall(rt, tu_rt) | ((ms | mu) & busy);
        check("stall",   stall,   exp_stall);
        check("ready_M", ready_M, (h_dst[1] != 0) && remaining(1) == 0);
        check("ready_W", ready_W, h_dst[2] != 0);
        check("dst_M",   dst_M,   h_dst[1]);
        check("dst_W",   dst_W,   h_dst[2]);
        check("md_busy", md_busy, busy);
        st = stall;
        @(posedge clk);
        if (rst) begin
            for (int a = 0; a < 3; a++) begin h_dst[a] = 0; h_tnew[a] = 0; end
            md_until = 0;
        end else begin
            h_dst[2] = h_dst[1]; h_tnew[2] = h_tnew[1];
            h_dst[1] = h_dst[0]; h_tnew[1] = h_tnew[0];
            h_dst[0] = exp_stall ? 5'd0 : dst;
            h_tnew[0] = exp_stall ? 0 : int'(tnew);
            if (ms && !exp_stall)
                md_until = cyc + 1 + (mdiv ? DIV_CYCLES : MULT_CYCLES);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
    endtask

    // Repeat one D instruction until it advances; returns its stall cycles.
    task automatic hold(input logic [4:0] rs, input logic [1:0] tu_rs,
                        input logic [4:0] dst, input logic [1:0] tnew,
                        input logic ms, input logic mdiv, input logic mu,
                        output int n);
        logic s;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, rs, tu_rs, 5'd0, 2'd3, dst, tnew, ms, mdiv, mu, s);
            if (!s) return;
            n++;
        end
        check("hold_timeout", 1, 0);
    endtask

    initial begin
        logic s;
        int   n;
        for (int a = 0; a < 3; a++) begin h_dst[a] = 0; h_tnew[a] = 0; end
        reset = 1'b1; rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3;
        dst_D = 0; tnew_D = 0; md_start_D = 0; md_div_D = 0; md_use_D = 0;
        @(negedge clk);
        step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        check("rst_ready_M", ready_M, 0);
        check("rst_ready_W", ready_W, 0);
        check("rst_md_busy", md_busy, 0);

        // lw $1 ; addu $3,$1,$2 (Tuse 1): one stall cycle
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, s);
        hold(5'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, n);
        check("lw_tuse1_stalls", n, 1);
        idle(3);
        // addu $2 ; beq $2,$0 (Tuse 0): one stall cycle
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, s);
        hold(5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("alu_tuse0_stalls", n, 1);
        idle(3);
        // lw $4 ; beq $4 (Tuse 0): two stall cycles
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0, s);
        hold(5'd4, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("lw_tuse0_stalls", n, 2);
        idle(3);
        // lw $0 ; beq $0: never stalls
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, s);
        hold(5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("r0_stalls", n, 0);
        idle(3);
        // mult ; mflo : MULT_CYCLES stalls
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, s);
        hold(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1, n);
        check("mult_mflo_stalls", n, MULT_CYCLES);
        idle(2);
        // div ; mflo : DIV_CYCLES stalls
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, s);
        hold(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1, n);
        check("div_mflo_stalls", n, DIV_CYCLES);
        idle(2);
        // mult ; mult ; mflo : the second mult only loads once it advances
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, s);
        hold(5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, n);
        check("mult_mult_stalls", n, MULT_CYCLES);
        hold(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1, n);
        check("mult2_mflo_stalls", n, MULT_CYCLES);
        idle(2);

        // Reset mid-countdown with an lw in E
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, s);
        idle(2);
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, s);
        step(1'b1, 5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        reset = 1'b0; rs_D = 5'd7; tuse_rs_D = 2'd0; #1;
        check("post_rst_busy",  md_busy, 0);
        check("post_rst_stall", stall,   0);
        check("post_rst_dst_M", dst_M,   0);
        check("post_rst_dst_W", dst_W,   0);
        check("post_rst_rdy_M", ready_M, 0);
        check("post_rst_rdy_W", ready_W, 0);
        @(negedge clk);

        // Randomized traffic on a few registers so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            logic ms;
            ms = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 79) == 0,
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 ms, 1'($urandom_range(0, 1)), ~ms & ($urandom_range(0, 5) == 0), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
